dac_sample_feeder: RTL
======================

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH, 4, FIFO depth in 12-bit words; power of two, 2 to 16.
  RESET_CODE, 12'h000, value of sample_out after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, sole system clock.
  rst, in, 1, synchronous active-high reset.
  sclk_in, in, 1, external serial clock; asynchronous to clk.
  sdata_in, in, 1, serial data, MSB first; asynchronous.
  cs_n_in, in, 1, active-low frame select; asynchronous.
  period_start, in, 1, one-clk pulse from the PWM DAC at its counter wrap.
  clear_flags, in, 1, clears the sticky flags.
  sample_out, out, 12, registered word presented to the PWM DAC input.
  fifo_level, out, $clog2(DEPTH)+1, current FIFO occupancy.
  overflow, out, 1, sticky flag: a word was dropped because the FIFO was full.
  underflow, out, 1, sticky flag: period_start arrived while the FIFO was empty.
REQ-003 Clock and reset: the block SHALL use one clock only; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL pass sclk_in, sdata_in and cs_n_in through separate two-flop synchronizers before any use.
REQ-005 A serial edge SHALL be recognized on any cycle where the synchronized sclk is 1 and its value on the previous cycle was 0.
REQ-006 On a recognized edge with synchronized cs_n low, the block SHALL shift the synchronized sdata into a 12-bit shift register (MSB first) and increment the bit counter (0..11).
REQ-007 When the 12th bit is shifted in, the bit counter SHALL return to 0 and the assembled word SHALL be pushed into the FIFO on the next cycle.
REQ-008 Several words per frame SHALL be supported; bit 13 of a frame starts a new word.
REQ-009 When synchronized cs_n is high, the bit counter SHALL be held at 0 and any partial word SHALL be discarded with no push.
REQ-010 A push when the FIFO is full SHALL:
  - drop the incoming word;
  - set overflow;
  - leave the FIFO contents and fifo_level unchanged.
REQ-011 When period_start is high and the FIFO is non-empty, the block SHALL pop the oldest word, and sample_out SHALL show that word on the next cycle.
REQ-012 When period_start is high and the FIFO is empty, the block SHALL:
  - set underflow;
  - hold sample_out at its previous value.
REQ-013 When a push and a pop happen in the same cycle:
  - both SHALL succeed when the FIFO is non-empty, including when it is full, with no overflow and fifo_level unchanged;
  - when the FIFO is empty, the pop SHALL cause underflow and the push SHALL be stored. There is no bypass; the word is output at the next period_start.
REQ-014 clear_flags SHALL clear overflow and underflow on the next cycle; if a set event occurs in the same cycle, the set SHALL win.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL range from 0 to DEPTH inclusive.
REQ-016 Supported serial input rate: sclk_in high and low phases SHALL each be at least 3 clk periods. Behaviour at faster rates is undefined.

Reset
REQ-017 While rst is high, at each clk edge the block SHALL set:
  - sample_out = RESET_CODE;
  - fifo_level = 0, read and write pointers = 0;
  - bit counter and shift register = 0;
  - overflow = 0, underflow = 0;
  - synchronizer flops to the idle levels sclk=0, cs_n=1.
REQ-018 Reset asserted mid-frame SHALL abandon the partial word. After reset is released, no word SHALL be pushed until a fresh 12-bit sequence is shifted in.
REQ-019 Outputs SHALL be valid on the first cycle after rst is released.

Verification
REQ-020 Single word: frame shifting 12'hA5C, then a period_start pulse.
  Required: fifo_level goes 0->1->0; sample_out = 12'hA5C one cycle after period_start; no flags set.
REQ-021 Fill and overflow (DEPTH=4): five words 001..005 in one frame, no period_start.
  Required: fifo_level = 4 and overflow = 1.
  Then four period_start pulses. Required: sample_out sequence 001, 002, 003, 004.
REQ-022 Underflow and hold: after word 12'h7FF is output, period_start with the FIFO empty.
  Required: sample_out stays 12'h7FF; underflow = 1.
  Then clear_flags. Required: underflow = 0 on the next cycle.
REQ-023 Aborted frame: cs_n_in rises after 7 bits; a new frame then sends 12'h123.
  Required: exactly one word is pushed, and it is 12'h123.
REQ-024 Simultaneous events with the FIFO full: period_start coincides with the push cycle.
  Required: fifo_level stays 4; overflow stays 0; pop order is preserved.
REQ-025 Reset mid-frame: rst asserted after 5 bits, then released, then 12 new bits 12'hFFF and a period_start.
  Required: sample_out = RESET_CODE before the period_start and 12'hFFF after it.

Source files
------------

// File: rtl/dac_sample_feeder.sv
// Serial-to-parallel sample feeder for a PWM DAC: synchronizes an external
// SPI-like 12-bit stream, queues words in a FIFO, and pops one per PWM period.
module dac_sample_feeder #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [11:0] RESET_CODE = 12'h000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk_in,
  input  logic                     sdata_in,
  input  logic                     cs_n_in,
  input  logic                     period_start,
  input  logic                     clear_flags,
  output logic [11:0]              sample_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = 12;

  logic          sclk_s1, sclk_s2, sclk_prev;
  logic          sdata_s1, sdata_s2;
  logic          cs_s1, cs_s2;
  logic [3:0]    bit_cnt;
  logic [WW-1:0] shift_q;
  logic [WW-1:0] push_word;
  logic          push_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] mem [DEPTH];

  logic sclk_rise_c, pop_c, push_ok_c, full_c, empty_c, ovf_set_c, udf_set_c;

  assign sclk_rise_c = sclk_s2 & ~sclk_prev;
  assign full_c      = (fifo_level == LW'(DEPTH));
  assign empty_c     = (fifo_level == '0);
  assign pop_c       = period_start & ~empty_c;
  // A full FIFO still accepts a word when the same cycle frees a slot.
  assign push_ok_c   = push_q & (~full_c | pop_c);
  assign ovf_set_c   = push_q & full_c & ~pop_c;
  assign udf_set_c   = period_start & empty_c;

  // Two-flop synchronizers, reset to the idle bus levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sdata_s1  <= 1'b0;
      sdata_s2  <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
    end else begin
      sclk_s1   <= sclk_in;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sdata_s1  <= sdata_in;
      sdata_s2  <= sdata_s1;
      cs_s1     <= cs_n_in;
      cs_s2     <= cs_s1;
    end
  end

  // Shift register and bit counter; a completed word is pushed one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      push_word <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (cs_s2) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (sclk_rise_c) begin
        shift_q <= {shift_q[WW-2:0], sdata_s2};
        if (bit_cnt == 4'd11) begin
          bit_cnt   <= '0;
          push_q    <= 1'b1;
          push_word <= {shift_q[WW-2:0], sdata_s2};
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sample_out <= RESET_CODE;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) begin
        rd_ptr     <= rd_ptr + AW'(1);
        sample_out <= mem[rd_ptr];
      end
      if (push_ok_c && !pop_c)      fifo_level <= fifo_level + LW'(1);
      else if (pop_c && !push_ok_c) fifo_level <= fifo_level - LW'(1);
      if (ovf_set_c)        overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (udf_set_c)        underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
  end

endmodule
